// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master (cpu / dma) arbiter for a single shared memory bus.
//            Round-robin on ties, registered grants, one idle HANDOVER cycle
//            between owners. mem_* outputs are a combinational mux of the
//            granted master's request fields, zero when no one owns the bus.
// Config   : BUS_ARBITER_HOLD_WATCHDOG_EN - when defined, a grant that has
//            lasted MAX_HOLD cycles is pre-empted if the other master is
//            waiting, and hold_timeout pulses for one cycle.
// Ports    : clk, rst (sync, active-high)
//            cpu_req/addr/w_notr/wdata, dma_req/addr/w_notr/wdata (inputs)
//            cpu_gnt, dma_gnt (registered grants)
//            mem_addr, mem_w_notr, mem_wdata (shared bus)
//            owner (0 = cpu, 1 = dma), hold_timeout (watchdog pulse)
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int SZ       = 8,
    parameter int WSZ      = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_req,
    input  logic           dma_req,
    input  logic [SZ-1:0]  cpu_addr,
    input  logic [SZ-1:0]  dma_addr,
    input  logic           cpu_w_notr,
    input  logic           dma_w_notr,
    input  logic [WSZ-1:0] cpu_wdata,
    input  logic [WSZ-1:0] dma_wdata,
    output logic           cpu_gnt,
    output logic           dma_gnt,
    output logic [SZ-1:0]  mem_addr,
    output logic           mem_w_notr,
    output logic [WSZ-1:0] mem_wdata,
    output logic           owner,
    output logic           hold_timeout
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_GNT_CPU  = 2'd1;
    localparam logic [1:0] c_GNT_DMA  = 2'd2;
    localparam logic [1:0] c_HANDOVER = 2'd3;

    // A zero hold limit would pre-empt every grant before it is used.
    generate
        if (MAX_HOLD < 1) begin : g_max_hold_check
            $error("bus_arbiter: MAX_HOLD must be at least 1");
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_cpu_gnt;
    logic       r_dma_gnt;
    logic       r_owner;
    logic       w_owner_next;
    logic       w_preempt;

`ifdef BUS_ARBITER_HOLD_WATCHDOG_EN
    localparam int c_CNT_W = ($clog2(MAX_HOLD + 1) > 8) ? $clog2(MAX_HOLD + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_HOLD);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // r_hold_cnt = number of grant cycles including the current one; it
    // saturates at MAX_HOLD so a late request from the other master still
    // triggers pre-emption immediately.
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic [c_CNT_W-1:0] w_hold_cnt_next;
    logic               r_hold_timeout;

    always_comb begin
        w_preempt = 1'b0;
        if (r_hold_cnt >= c_CNT_MAX) begin
            w_preempt = ((r_state == c_GNT_CPU) && dma_req) ||
                        ((r_state == c_GNT_DMA) && cpu_req);
        end
    end

    always_comb begin
        w_hold_cnt_next = '0;
        if ((w_state_next == c_GNT_CPU) || (w_state_next == c_GNT_DMA)) begin
            if (r_state == w_state_next) begin
                w_hold_cnt_next = (r_hold_cnt >= c_CNT_MAX) ? r_hold_cnt
                                                            : r_hold_cnt + c_CNT_ONE;
            end else begin
                w_hold_cnt_next = c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt     <= '0;
            r_hold_timeout <= 1'b0;
        end else begin
            r_hold_cnt     <= w_hold_cnt_next;
            r_hold_timeout <= w_preempt;
        end
    end

    assign hold_timeout = r_hold_timeout;
`else
    assign w_preempt    = 1'b0;
    assign hold_timeout = 1'b0;
`endif

    // Next-state logic. On a tie the master that did not own the bus last
    // wins; after the HANDOVER following a pre-emption this naturally hands
    // the bus to the waiting master.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (cpu_req && dma_req) begin
                    w_state_next = r_owner ? c_GNT_CPU : c_GNT_DMA;
                end else if (cpu_req) begin
                    w_state_next = c_GNT_CPU;
                end else if (dma_req) begin
                    w_state_next = c_GNT_DMA;
                end
            end
            c_GNT_CPU: begin
                if (!cpu_req || w_preempt) begin
                    w_state_next = c_HANDOVER;
                end
            end
            c_GNT_DMA: begin
                if (!dma_req || w_preempt) begin
                    w_state_next = c_HANDOVER;
                end
            end
            c_HANDOVER: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_owner_next = r_owner;
        if (w_state_next == c_GNT_CPU) begin
            w_owner_next = 1'b0;
        end else if (w_state_next == c_GNT_DMA) begin
            w_owner_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cpu_gnt <= 1'b0;
            r_dma_gnt <= 1'b0;
            r_owner   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cpu_gnt <= (w_state_next == c_GNT_CPU);
            r_dma_gnt <= (w_state_next == c_GNT_DMA);
            r_owner   <= w_owner_next;
        end
    end

    // Shared bus: follows the granted master's live inputs, parked at zero
    // (read direction) otherwise.
    always_comb begin
        mem_addr   = '0;
        mem_w_notr = 1'b0;
        mem_wdata  = '0;
        if (r_state == c_GNT_CPU) begin
            mem_addr   = cpu_addr;
            mem_w_notr = cpu_w_notr;
            mem_wdata  = cpu_wdata;
        end else if (r_state == c_GNT_DMA) begin
            mem_addr   = dma_addr;
            mem_w_notr = dma_w_notr;
            mem_wdata  = dma_wdata;
        end
    end

    assign cpu_gnt = r_cpu_gnt;
    assign dma_gnt = r_dma_gnt;
    assign owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter. The stimulus thread drives
//            inputs on the falling edge and queues the outputs expected after
//            the next rising edge; a monitor thread pops and compares them
//            1 time unit after each rising edge. Expectations for the hold
//            watchdog follow BUS_ARBITER_HOLD_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int c_SZ       = 8;
    localparam int c_WSZ      = 8;
    localparam int c_MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cpu_req = 1'b0;
    logic             dma_req = 1'b0;
    logic [c_SZ-1:0]  cpu_addr = '0;
    logic [c_SZ-1:0]  dma_addr = '0;
    logic             cpu_w_notr = 1'b0;
    logic             dma_w_notr = 1'b0;
    logic [c_WSZ-1:0] cpu_wdata = '0;
    logic [c_WSZ-1:0] dma_wdata = '0;
    logic             cpu_gnt;
    logic             dma_gnt;
    logic [c_SZ-1:0]  mem_addr;
    logic             mem_w_notr;
    logic [c_WSZ-1:0] mem_wdata;
    logic             owner;
    logic             hold_timeout;

    always #5 clk = ~clk;

    bus_arbiter #(
        .SZ       (c_SZ),
        .WSZ      (c_WSZ),
        .MAX_HOLD (c_MAX_HOLD)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .dma_req      (dma_req),
        .cpu_addr     (cpu_addr),
        .dma_addr     (dma_addr),
        .cpu_w_notr   (cpu_w_notr),
        .dma_w_notr   (dma_w_notr),
        .cpu_wdata    (cpu_wdata),
        .dma_wdata    (dma_wdata),
        .cpu_gnt      (cpu_gnt),
        .dma_gnt      (dma_gnt),
        .mem_addr     (mem_addr),
        .mem_w_notr   (mem_w_notr),
        .mem_wdata    (mem_wdata),
        .owner        (owner),
        .hold_timeout (hold_timeout)
    );

    // Packed expectation: {cpu_gnt, dma_gnt, owner, hold_timeout,
    //                      mem_addr, mem_w_notr, mem_wdata}
    typedef struct {
        string       nm;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic drv(input logic r, input logic cr, input logic [7:0] ca,
                       input logic cw, input logic [7:0] cd, input logic dr,
                       input logic [7:0] da, input logic dw, input logic [7:0] dd);
        rst        = r;
        cpu_req    = cr;
        cpu_addr   = ca;
        cpu_w_notr = cw;
        cpu_wdata  = cd;
        dma_req    = dr;
        dma_addr   = da;
        dma_w_notr = dw;
        dma_wdata  = dd;
    endtask

    // Queue the outputs expected after the coming rising edge, then advance.
    task automatic cyc(input string nm, input logic cg, input logic dg,
                       input logic own, input logic ht, input logic [7:0] a,
                       input logic wn, input logic [7:0] d);
        exp_t e;
        e.nm = nm;
        e.v  = {cg, dg, own, ht, a, wn, d};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_exp(input string nm, input logic own);
        cyc(nm, 1'b0, 1'b0, own, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [20:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {cpu_gnt, dma_gnt, owner, hold_timeout,
                       mem_addr, mem_w_notr, mem_wdata};
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got {cg,dg,own,ht,addr,wn,wd}=%b,%b,%b,%b,%h,%b,%h required %b,%b,%b,%b,%h,%b,%h",
                             e.nm, got[20], got[19], got[18], got[17], got[16:9], got[8], got[7:0],
                             e.v[20], e.v[19], e.v[18], e.v[17], e.v[16:9], e.v[8], e.v[7:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        @(negedge clk);

        // Reset, then a single cpu write request.
        drv(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        idle_exp("reset_state", 0);
        drv(0, 1, 8'd15, 1, 8'hdd, 0, 8'h00, 0, 8'h00);
        cyc("cpu_grant", 1, 0, 0, 0, 8'd15, 1, 8'hdd);
        drv(0, 1, 8'd16, 0, 8'h5a, 0, 8'h00, 0, 8'h00);
        cyc("cpu_bus_follows", 1, 0, 0, 0, 8'd16, 0, 8'h5a);
        drv(0, 0, 8'd16, 0, 8'h5a, 0, 8'h00, 0, 8'h00);
        idle_exp("cpu_handover", 0);
        idle_exp("cpu_idle", 0);

        // Tie after reset: dma first, then cpu after HANDOVER + IDLE.
        drv(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        idle_exp("reset2", 0);
        drv(0, 1, 8'h21, 0, 8'h11, 1, 8'h42, 1, 8'h99);
        cyc("tie_dma_first", 0, 1, 1, 0, 8'h42, 1, 8'h99);
        cyc("tie_dma_hold", 0, 1, 1, 0, 8'h42, 1, 8'h99);
        drv(0, 1, 8'h21, 0, 8'h11, 0, 8'h42, 1, 8'h99);
        idle_exp("tie_handover", 1);
        idle_exp("tie_idle", 1);
        cyc("tie_cpu_next", 1, 0, 0, 0, 8'h21, 0, 8'h11);
        drv(0, 0, 8'h21, 0, 8'h11, 0, 8'h00, 0, 8'h00);
        idle_exp("tie_cpu_handover", 0);
        idle_exp("tie_cpu_idle", 0);

        // dma at address 12; a cpu pulse must not disturb it.
        drv(0, 0, 8'h00, 0, 8'h00, 1, 8'd12, 0, 8'h34);
        cyc("dma_grant12", 0, 1, 1, 0, 8'd12, 0, 8'h34);
        drv(0, 1, 8'h66, 1, 8'h77, 1, 8'd12, 0, 8'h34);
        cyc("cpu_pulse_blocked", 0, 1, 1, 0, 8'd12, 0, 8'h34);
        drv(0, 0, 8'h66, 1, 8'h77, 1, 8'd12, 0, 8'h34);
        cyc("cpu_pulse_gone", 0, 1, 1, 0, 8'd12, 0, 8'h34);
        drv(0, 0, 8'h00, 0, 8'h00, 0, 8'd12, 0, 8'h34);
        idle_exp("dma12_handover", 1);
        idle_exp("dma12_idle", 1);

        // Reset during GNT_DMA: no HANDOVER, so a held request regrants at once.
        drv(0, 0, 8'h00, 0, 8'h00, 1, 8'h77, 1, 8'h01);
        cyc("dma_grant77", 0, 1, 1, 0, 8'h77, 1, 8'h01);
        drv(1, 0, 8'h00, 0, 8'h00, 1, 8'h77, 1, 8'h01);
        idle_exp("rst_mid_grant", 0);
        drv(0, 0, 8'h00, 0, 8'h00, 1, 8'h77, 1, 8'h01);
        cyc("regrant_after_rst", 0, 1, 1, 0, 8'h77, 1, 8'h01);
        drv(0, 0, 8'h00, 0, 8'h00, 0, 8'h77, 1, 8'h01);
        idle_exp("rst_seq_handover", 1);
        idle_exp("rst_seq_idle", 1);

        // Tie with owner=dma: cpu wins; one-cycle cpu request, then dma.
        drv(0, 1, 8'h33, 1, 8'hc3, 1, 8'h44, 0, 8'h55);
        cyc("tie_cpu_wins", 1, 0, 0, 0, 8'h33, 1, 8'hc3);
        drv(0, 0, 8'h33, 1, 8'hc3, 1, 8'h44, 0, 8'h55);
        idle_exp("short_cpu_handover", 0);
        idle_exp("short_cpu_idle", 0);
        cyc("dma_after_cpu", 0, 1, 1, 0, 8'h44, 0, 8'h55);
        drv(0, 0, 8'h00, 0, 8'h00, 0, 8'h44, 0, 8'h55);
        idle_exp("dma44_handover", 1);
        idle_exp("dma44_idle", 1);

        // cpu holds its request for 10 cycles while dma waits (owner=dma,
        // so the tie goes to cpu).
        drv(0, 1, 8'h0a, 1, 8'ha0, 1, 8'h0b, 0, 8'hb0);
`ifdef BUS_ARBITER_HOLD_WATCHDOG_EN
        for (int k = 0; k < 4; k++) begin
            cyc("wd_cpu_grant", 1, 0, 0, 0, 8'h0a, 1, 8'ha0);
        end
        cyc("wd_timeout_pulse", 0, 0, 0, 1, 8'h00, 0, 8'h00);
        idle_exp("wd_idle", 0);
        for (int k = 0; k < 4; k++) begin
            cyc("wd_dma_grant", 0, 1, 1, 0, 8'h0b, 0, 8'hb0);
        end
        drv(0, 0, 8'h0a, 1, 8'ha0, 1, 8'h0b, 0, 8'hb0);
        cyc("wd_dma_keep", 0, 1, 1, 0, 8'h0b, 0, 8'hb0);
        drv(0, 0, 8'h00, 0, 8'h00, 0, 8'h0b, 0, 8'hb0);
        idle_exp("wd_dma_handover", 1);
        idle_exp("wd_end_idle", 1);
`else
        for (int k = 0; k < 10; k++) begin
            cyc("hold_cpu", 1, 0, 0, 0, 8'h0a, 1, 8'ha0);
        end
        drv(0, 0, 8'h0a, 1, 8'ha0, 1, 8'h0b, 0, 8'hb0);
        idle_exp("hold_handover", 0);
        drv(0, 0, 8'h00, 0, 8'h00, 0, 8'h0b, 0, 8'hb0);
        idle_exp("hold_idle", 0);
        idle_exp("hold_end_idle", 0);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
